// File: rtl/overlay_control_hls_deadlock_scheduler_if.sv
// ---------------------------------------------------------------------------
// overlay_control_hls_deadlock_scheduler_if
//
// Purpose: report channel of the HLS deadlock scheduler. It carries the
// confirmed monitor index and the detection timestamp over a valid/ready
// handshake.
//
// Signals:
//   report_valid  : scheduler -> consumer, report available
//   report_ready  : consumer -> scheduler, report accepted
//   report_idx    : scheduler -> consumer, confirmed monitor index (IDX_W)
//   report_cycles : scheduler -> consumer, detection timestamp (CNT_W)
//
// Modports:
//   master : scheduler side
//   slave  : consumer side
// ---------------------------------------------------------------------------
interface overlay_control_hls_deadlock_scheduler_if #(
  parameter int IDX_W = 2,
  parameter int CNT_W = 16
);
  logic             report_valid;
  logic             report_ready;
  logic [IDX_W-1:0] report_idx;
  logic [CNT_W-1:0] report_cycles;

  modport master (
    output report_valid,
    output report_idx,
    output report_cycles,
    input  report_ready
  );

  modport slave (
    input  report_valid,
    input  report_idx,
    input  report_cycles,
    output report_ready
  );
endinterface

// File: rtl/overlay_control_hls_deadlock_scheduler.sv
// ---------------------------------------------------------------------------
// overlay_control_hls_deadlock_scheduler
//
// Purpose: round-robin scanner over the block outputs of the per-instance
// HLS deadlock monitors. A monitor found blocked becomes a candidate and
// must stay blocked for PERSIST consecutive samples to be confirmed. The
// first confirmed index is reported over a valid/ready channel and kept as
// a sticky deadlock flag until clear.
//
// Parameters:
//   N_MON   : number of monitor block inputs (>= 1)
//   IDX_W   : index width (>= clog2(N_MON), >= 1)
//   PERSIST : consecutive blocked samples required to confirm (>= 1)
//   CNT_W   : width of persistence counter and timestamp
//
// Ports:
//   clock     : rising-edge clock
//   reset     : asynchronous active-high reset
//   mon_block : block outputs of the monitors, bit i = index i
//   enable    : scanning allowed while high
//   clear     : single-cycle pulse, drops report/deadlock, returns to IDLE
//   rpt       : report channel (master modport)
//   deadlock  : sticky deadlock flag
//   busy      : high while scanning or confirming
//
// Optional feature (macro DEADLOCK_SCHED_TIMESTAMP_EN):
//   When defined, a saturating free-running cycle counter is captured into
//   report_cycles on the edge that enters REPORT. When undefined,
//   report_cycles is always 0.
// ---------------------------------------------------------------------------
module overlay_control_hls_deadlock_scheduler #(
  parameter int N_MON   = 4,
  parameter int IDX_W   = 2,
  parameter int PERSIST = 16,
  parameter int CNT_W   = 16
) (
  input  logic                                           clock,
  input  logic                                           reset,
  input  logic [N_MON-1:0]                               mon_block,
  input  logic                                           enable,
  input  logic                                           clear,
  overlay_control_hls_deadlock_scheduler_if.master       rpt,
  output logic                                           deadlock,
  output logic                                           busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SCAN    = 3'd1,
    S_CONFIRM = 3'd2,
    S_REPORT  = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_MON - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] PERSIST_M1 = CNT_W'(PERSIST - 1);

  state_t           state_q,    state_d;
  logic [IDX_W-1:0] ptr_q,      ptr_d;
  logic [IDX_W-1:0] cand_q,     cand_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             valid_q,    valid_d;
  logic [IDX_W-1:0] idx_q,      idx_d;
  logic [CNT_W-1:0] cycles_q,   cycles_d;
  logic             deadlock_q, deadlock_d;
  logic             busy_q,     busy_d;
  logic [CNT_W-1:0] ts_capture;
  logic             enter_report;

  // Next index in round-robin order; wraps at N_MON-1 even when N_MON is
  // not a power of two.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p);
    if (p == LAST_IDX) return '0;
    else               return p + IDX_ONE;
  endfunction

  // Bit select that never reads past N_MON-1 regardless of IDX_W.
  function automatic logic bit_at(input logic [N_MON-1:0] v,
                                  input logic [IDX_W-1:0] i);
    logic b;
    b = 1'b0;
    for (int k = 0; k < N_MON; k++) begin
      if (i == IDX_W'(k)) b = v[k];
    end
    return b;
  endfunction

`ifdef DEADLOCK_SCHED_TIMESTAMP_EN
  logic [CNT_W-1:0] ts_q, ts_d;

  // Saturating cycle counter; the value latched on the REPORT entry edge is
  // the post-edge count, so an entry at edge k after reset reports k.
  always_comb begin
    ts_d = (ts_q == {CNT_W{1'b1}}) ? ts_q : ts_q + CNT_ONE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_d;
  end

  assign ts_capture = ts_d;
`else
  assign ts_capture = '0;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q;
    idx_d        = idx_q;
    cycles_d     = cycles_q;
    deadlock_d   = deadlock_q;
    enter_report = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_SCAN;
      end

      S_SCAN: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (bit_at(mon_block, ptr_q)) begin
          cand_d = ptr_q;
          cnt_d  = CNT_ONE;
          if (PERSIST == 1) enter_report = 1'b1;
          else              state_d      = S_CONFIRM;
        end else begin
          ptr_d = wrap_inc(ptr_q);
        end
      end

      // Only the candidate is watched; enable is deliberately ignored so a
      // confirmation in progress always resolves one way or the other.
      S_CONFIRM: begin
        if (bit_at(mon_block, cand_q)) begin
          if (cnt_q == PERSIST_M1) enter_report = 1'b1;
          else                     cnt_d        = cnt_q + CNT_ONE;
        end else begin
          state_d = S_SCAN;
          ptr_d   = wrap_inc(cand_q);
          cnt_d   = '0;
        end
      end

      S_REPORT: begin
        if (rpt.report_ready) begin
          state_d = S_HALT;
          valid_d = 1'b0;
        end
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (enter_report) begin
      state_d    = S_REPORT;
      valid_d    = 1'b1;
      deadlock_d = 1'b1;
      idx_d      = cand_d;
      cycles_d   = ts_capture;
    end

    // clear overrides every transition above, including a handshake.
    if (clear) begin
      state_d    = S_IDLE;
      ptr_d      = ptr_q;
      cand_d     = cand_q;
      cnt_d      = '0;
      valid_d    = 1'b0;
      idx_d      = '0;
      cycles_d   = '0;
      deadlock_d = 1'b0;
    end

    busy_d = (state_d == S_SCAN) || (state_d == S_CONFIRM);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      cand_q     <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      cycles_q   <= '0;
      deadlock_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
      cycles_q   <= cycles_d;
      deadlock_q <= deadlock_d;
      busy_q     <= busy_d;
    end
  end

  assign rpt.report_valid  = valid_q;
  assign rpt.report_idx    = idx_q;
  assign rpt.report_cycles = cycles_q;
  assign deadlock          = deadlock_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_overlay_control_hls_deadlock_scheduler.sv
module tb_overlay_control_hls_deadlock_scheduler;

`ifdef DEADLOCK_SCHED_TIMESTAMP_EN
  localparam logic [15:0] EXP_TS = 16'd37;
`else
  localparam logic [15:0] EXP_TS = 16'd0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] mon1  = 4'b0000;
  logic       en1   = 1'b0;
  logic       clr1  = 1'b0;
  logic       dl1, busy1;
  logic [3:0] mon2  = 4'b0000;
  logic       en2   = 1'b0;
  logic       clr2  = 1'b0;
  logic       dl2, busy2;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  overlay_control_hls_deadlock_scheduler_if #(.IDX_W(2), .CNT_W(16)) if1 ();
  overlay_control_hls_deadlock_scheduler_if #(.IDX_W(2), .CNT_W(16)) if2 ();

  overlay_control_hls_deadlock_scheduler #(
    .N_MON(4), .IDX_W(2), .PERSIST(4), .CNT_W(16)
  ) dut1 (
    .clock(clock), .reset(reset), .mon_block(mon1), .enable(en1),
    .clear(clr1), .rpt(if1), .deadlock(dl1), .busy(busy1)
  );

  overlay_control_hls_deadlock_scheduler #(
    .N_MON(4), .IDX_W(2), .PERSIST(1), .CNT_W(16)
  ) dut2 (
    .clock(clock), .reset(reset), .mon_block(mon2), .enable(en2),
    .clear(clr2), .rpt(if2), .deadlock(dl2), .busy(busy2)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    if1.report_ready = 1'b0;
    if2.report_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    total++; if (if1.report_valid !== 1'b0) begin bad++; $display("FAIL reset_valid1 got=%0b want=0", if1.report_valid); end
    total++; if (if1.report_idx !== 2'd0) begin bad++; $display("FAIL reset_idx1 got=%0d want=0", if1.report_idx); end
    total++; if (if1.report_cycles !== 16'd0) begin bad++; $display("FAIL reset_cycles1 got=%0d want=0", if1.report_cycles); end
    total++; if (dl1 !== 1'b0) begin bad++; $display("FAIL reset_deadlock1 got=%0b want=0", dl1); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy1 got=%0b want=0", busy1); end
    total++; if ({if2.report_valid, dl2, busy2} !== 3'b000) begin bad++; $display("FAIL reset_dut2 got=%b want=000", {if2.report_valid, dl2, busy2}); end
  endtask

  // Scan starts at edge 31 after reset release; REPORT entry lands on edge 37.
  task automatic test_single_block;
    mon1 = 4'b0100;
    en1  = 1'b0;
    reset = 1'b0;
    repeat (30) tick();
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL idle_busy got=%0b want=0", busy1); end
    total++; if (if1.report_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%0b want=0", if1.report_valid); end
    en1 = 1'b1;
    tick();
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL scan_busy got=%0b want=1", busy1); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (if1.report_valid !== 1'b0 || busy1 !== 1'b1) begin bad++; $display("FAIL single_pre step=%0d valid=%0b busy=%0b want valid=0 busy=1", i, if1.report_valid, busy1); end
    end
    tick();
    total++; if (if1.report_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b want=1", if1.report_valid); end
    total++; if (if1.report_idx !== 2'd2) begin bad++; $display("FAIL single_idx got=%0d want=2", if1.report_idx); end
    total++; if (dl1 !== 1'b1) begin bad++; $display("FAIL single_deadlock got=%0b want=1", dl1); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL single_busy got=%0b want=0", busy1); end
    total++; if (if1.report_cycles !== EXP_TS) begin bad++; $display("FAIL timestamp got=%0d want=%0d", if1.report_cycles, EXP_TS); end
  endtask

  task automatic test_backpressure;
    if1.report_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mon1 = 4'(i);
      tick();
      total++; if (if1.report_valid !== 1'b1 || if1.report_idx !== 2'd2 || dl1 !== 1'b1 || if1.report_cycles !== EXP_TS) begin
        bad++; $display("FAIL bp_hold step=%0d valid=%0b idx=%0d dl=%0b cyc=%0d want 1/2/1/%0d", i, if1.report_valid, if1.report_idx, dl1, if1.report_cycles, EXP_TS);
      end
    end
    if1.report_ready = 1'b1;
    tick();
    total++; if (if1.report_valid !== 1'b0) begin bad++; $display("FAIL bp_xfer_valid got=%0b want=0", if1.report_valid); end
    total++; if (dl1 !== 1'b1 || if1.report_idx !== 2'd2) begin bad++; $display("FAIL halt_hold dl=%0b idx=%0d want 1/2", dl1, if1.report_idx); end
    if1.report_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mon1 = 4'b1111;
      tick();
      total++; if (if1.report_valid !== 1'b0 || busy1 !== 1'b0 || dl1 !== 1'b1) begin
        bad++; $display("FAIL halt_ignore step=%0d valid=%0b busy=%0b dl=%0b want 0/0/1", i, if1.report_valid, busy1, dl1);
      end
    end
  endtask

  task automatic test_clear_priority;
    en1  = 1'b0;
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    total++; if ({if1.report_valid, dl1, busy1} !== 3'b000 || if1.report_idx !== 2'd0 || if1.report_cycles !== 16'd0) begin
      bad++; $display("FAIL clear_halt valid=%0b dl=%0b busy=%0b idx=%0d cyc=%0d want all 0", if1.report_valid, dl1, busy1, if1.report_idx, if1.report_cycles);
    end
    // ptr was retained at 2, so the hit comes on the first scan sample.
    mon1 = 4'b0100;
    en1  = 1'b1;
    tick();
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL rescan_busy got=%0b want=1", busy1); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (if1.report_valid !== 1'b0) begin bad++; $display("FAIL rescan_pre step=%0d got=%0b want=0", i, if1.report_valid); end
    end
    tick();
    total++; if (if1.report_valid !== 1'b1 || if1.report_idx !== 2'd2) begin bad++; $display("FAIL rescan_report valid=%0b idx=%0d want 1/2", if1.report_valid, if1.report_idx); end
    clr1 = 1'b1;
    if1.report_ready = 1'b1;
    tick();
    clr1 = 1'b0;
    if1.report_ready = 1'b0;
    total++; if ({if1.report_valid, dl1, busy1} !== 3'b000 || if1.report_idx !== 2'd0 || if1.report_cycles !== 16'd0) begin
      bad++; $display("FAIL clear_prio valid=%0b dl=%0b busy=%0b idx=%0d cyc=%0d want all 0", if1.report_valid, dl1, busy1, if1.report_idx, if1.report_cycles);
    end
    tick();
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL reenable_busy got=%0b want=1", busy1); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (if1.report_valid !== 1'b0) begin bad++; $display("FAIL reenable_pre step=%0d got=%0b want=0", i, if1.report_valid); end
    end
    tick();
    total++; if (if1.report_valid !== 1'b1 || if1.report_idx !== 2'd2) begin bad++; $display("FAIL reenable_report valid=%0b idx=%0d want 1/2", if1.report_valid, if1.report_idx); end
    en1  = 1'b0;
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
  endtask

  // ptr=2 on entry: samples 2,3,0 low, then monitor 1 blocks for 3 samples.
  task automatic test_glitch;
    mon1 = 4'b0010;
    en1  = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (if1.report_valid !== 1'b0 || busy1 !== 1'b1 || dl1 !== 1'b0) begin
        bad++; $display("FAIL glitch_run step=%0d valid=%0b busy=%0b dl=%0b want 0/1/0", i, if1.report_valid, busy1, dl1);
      end
    end
    mon1 = 4'b0000;
    tick();
    total++; if (if1.report_valid !== 1'b0 || dl1 !== 1'b0 || busy1 !== 1'b1) begin
      bad++; $display("FAIL glitch_drop valid=%0b dl=%0b busy=%0b want 0/0/1", if1.report_valid, dl1, busy1);
    end
    // Back in SCAN at ptr=2: a block on monitor 2 is sampled immediately.
    mon1 = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (if1.report_valid !== 1'b0) begin bad++; $display("FAIL glitch_ptr_pre step=%0d got=%0b want=0", i, if1.report_valid); end
    end
    tick();
    total++; if (if1.report_valid !== 1'b1 || if1.report_idx !== 2'd2) begin bad++; $display("FAIL glitch_ptr valid=%0b idx=%0d want 1/2", if1.report_valid, if1.report_idx); end
  endtask

  task automatic test_async_reset;
    #2;
    reset = 1'b1;
    #1;
    total++; if ({if1.report_valid, dl1, busy1} !== 3'b000 || if1.report_idx !== 2'd0) begin
      bad++; $display("FAIL async_reset valid=%0b dl=%0b busy=%0b idx=%0d want all 0", if1.report_valid, dl1, busy1, if1.report_idx);
    end
    en1  = 1'b0;
    mon1 = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_wrap_persist1;
    mon2  = 4'b1000;
    en2   = 1'b1;
    reset = 1'b0;
    tick();
    total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL p1_busy got=%0b want=1", busy2); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (if2.report_valid !== 1'b0) begin bad++; $display("FAIL p1_pre step=%0d got=%0b want=0", i, if2.report_valid); end
    end
    tick();
    total++; if (if2.report_valid !== 1'b1 || if2.report_idx !== 2'd3 || dl2 !== 1'b1 || busy2 !== 1'b0) begin
      bad++; $display("FAIL p1_first valid=%0b idx=%0d dl=%0b busy=%0b want 1/3/1/0", if2.report_valid, if2.report_idx, dl2, busy2);
    end
    en2  = 1'b0;
    clr2 = 1'b1;
    tick();
    clr2 = 1'b0;
    total++; if (if2.report_valid !== 1'b0 || dl2 !== 1'b0) begin bad++; $display("FAIL p1_clear valid=%0b dl=%0b want 0/0", if2.report_valid, dl2); end
    en2 = 1'b1;
    tick();
    total++; if (busy2 !== 1'b1 || if2.report_valid !== 1'b0) begin bad++; $display("FAIL p1_scan3 busy=%0b valid=%0b want 1/0", busy2, if2.report_valid); end
    tick();
    total++; if (if2.report_valid !== 1'b1 || if2.report_idx !== 2'd3) begin bad++; $display("FAIL p1_hit3 valid=%0b idx=%0d want 1/3", if2.report_valid, if2.report_idx); end
    en2  = 1'b0;
    clr2 = 1'b1;
    tick();
    clr2 = 1'b0;
    mon2 = 4'b0001;
    en2  = 1'b1;
    tick();
    tick();
    total++; if (if2.report_valid !== 1'b0 || busy2 !== 1'b1) begin bad++; $display("FAIL p1_wrap_pre valid=%0b busy=%0b want 0/1", if2.report_valid, busy2); end
    tick();
    total++; if (if2.report_valid !== 1'b1 || if2.report_idx !== 2'd0 || dl2 !== 1'b1) begin
      bad++; $display("FAIL p1_wrap valid=%0b idx=%0d dl=%0b want 1/0/1", if2.report_valid, if2.report_idx, dl2);
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_backpressure();
    test_clear_priority();
    test_glitch();
    test_async_reset();
    test_wrap_persist1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/overlay_control_hls_deadlock_scheduler.md
# overlay_control_hls_deadlock_scheduler

Round-robin scheduler and confirmation controller for the per-instance HLS deadlock monitors of `overlay_control`. It scans the `block` outputs of up to `N_MON` `*_deadlock_idxN_monitor` instances, one per cycle. A candidate is accepted only if its monitor stays blocked for `PERSIST` consecutive samples. The first confirmed index is reported over a valid/ready handshake and latched as a sticky `deadlock` flag for the debug/status path.

## Interface
- `N_MON`, default 4: number of monitor `block` inputs; must be ≥1.
- `IDX_W`, default 2: index width; must be ≥ clog2(`N_MON`) and ≥1.
- `PERSIST`, default 16: consecutive blocked samples required to confirm; must be ≥1.
- `CNT_W`, default 16: width of the persistence counter and the timestamp.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `mon_block` in `N_MON`: `block` outputs of the monitors; bit i belongs to index i.
- `enable` in 1: scanning allowed while high.
- `clear` in 1: single-cycle pulse that drops any report or deadlock and returns to IDLE.
- `report_valid` out 1: report available.
- `report_ready` in 1: consumer accepts the report.
- `report_idx` out `IDX_W`: confirmed monitor index.
- `report_cycles` out `CNT_W`: detection timestamp (see Configuration).
- `deadlock` out 1: sticky deadlock flag.
- `busy` out 1: high in SCAN or CONFIRM.

## Operation
- **States:** IDLE, SCAN, CONFIRM, REPORT, HALT.
- **Reset values:** state=IDLE, ptr=0, cand=0, cnt=0; all outputs 0.
- **IDLE:**
  - `enable`=1 → SCAN, with ptr unchanged.
- **SCAN:**
  - Sample `mon_block[ptr]` each cycle.
  - If high: cand←ptr, cnt←1. Go to CONFIRM, or to REPORT directly when `PERSIST`=1.
  - If low: ptr←ptr+1, wrapping from `N_MON`-1 to 0.
  - `enable`=0 → IDLE, with ptr held.
- **CONFIRM:**
  - `mon_block[cand]` high and cnt=`PERSIST`-1 → REPORT.
  - `mon_block[cand]` high otherwise → cnt←cnt+1.
  - `mon_block[cand]` low → SCAN, ptr←cand+1 (wrapped), cnt←0.
  - `enable` has no effect in CONFIRM.
  - Other monitors are ignored while confirming.
- **REPORT:**
  - `report_valid`=1; `report_idx`=cand; `deadlock`=1.
  - `report_idx` and `report_cycles` are held stable while valid.
  - `report_ready`=1 → HALT, with `report_valid`←0.
- **HALT:**
  - `deadlock` stays 1 and `report_idx` holds cand.
  - No further scanning until `clear`.
- **clear:**
  - Acts in any state → IDLE next cycle.
  - Zeroes `deadlock`, `report_valid`, `report_idx`, `report_cycles` and cnt; ptr is kept.
  - `clear` takes priority over `report_ready` and over every other transition.
- **Counter width:** cnt is `CNT_W` bits; `PERSIST` must fit in `CNT_W` bits.
- **Async reset mid-operation:** immediate return to reset values; no report survives.

## Timing
- Scan rate: one monitor per cycle; a full scan takes `N_MON` cycles.
- Confirmation latency: a monitor first sampled high at edge E0 and held high yields `report_valid`=1 in the cycle after edge E0+`PERSIST`-1. With `PERSIST`=1 this is the cycle after E0.
- `deadlock` rises in the same cycle as `report_valid`.
- Worst-case detection latency from a stable block: `N_MON`-1+`PERSIST` cycles.
- Handshake:
  - The transfer happens on the edge where `report_valid` and `report_ready` are both 1.
  - `report_valid` is never withdrawn without a transfer or `clear`.
  - `report_ready` is ignored outside REPORT.
- `busy` is registered from state; it is high exactly when state is SCAN or CONFIRM.

## Configuration
- `DEADLOCK_SCHED_TIMESTAMP_EN` defined:
  - A free-running `CNT_W`-bit cycle counter runs from reset and saturates at all-ones.
  - Its value is captured into `report_cycles` on the edge that enters REPORT.
  - It is zeroed by reset only; `clear` does not affect it.
- Undefined: the counter is absent and `report_cycles` is tied to 0.

## Test plan
- **Single block:** N_MON=4, PERSIST=4, `enable`=1; `mon_block`=4'b0100 from reset release → ptr 0,1,2; `report_valid`=1 with `report_idx`=2 in the cycle after the 4th sample; `deadlock`=1.
- **Glitch rejection:** `mon_block[1]` high for 3 samples, then low → back to SCAN with ptr=2; no `report_valid`; `deadlock` stays 0.
- **Backpressure:** `report_ready`=0 for 10 cycles → `report_valid` and `report_idx` stay stable; `report_ready`=1 → HALT next cycle; `deadlock` stays 1; `mon_block` changes are ignored.
- **Clear priority:** `clear` and `report_ready` both high in REPORT → IDLE next cycle, all outputs 0; re-enable resumes scanning at the retained ptr.
- **Wrap and PERSIST=1:** only `mon_block[3]` high, ptr starting at 3 → scan order 3 hits at once and `report_idx`=3 one cycle later; after `clear`, only `mon_block[0]` high → ptr wraps 3→0 and `report_idx`=0.
- **Timestamp with the macro defined:** detection entering REPORT at edge 37 after reset → `report_cycles`=37; macro undefined → `report_cycles`=0.
